pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: id_valid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL: id_kind  input  2  00 ALU/other, 01 Bcond, 10 Jcond, 11 JAL.
REQ-005 SHALL: id_cond  input  4  condition code (encoding per REQ-013).
REQ-006 SHALL: psr_flags  input  5  {Z,C,F,L,N} from PSR.
REQ-007 SHALL: load_use  input  1  decode-stage load-use hazard.
REQ-008 SHALL: mem_busy  input  1  data memory not ready; pipeline must hold.
REQ-009 SHALL: stall, Br, Jmp, JAL  output  1 each  PC-register controls, combinational from state and inputs.
REQ-010 SHALL: flush  output  1  squash the wrong-path instruction in decode.
REQ-011 SHALL: mem_timeout  output  1  sticky watchdog error.
REQ-012 SHALL: redirect_cnt, stall_cnt  output  16 each  performance counters (REQ-026).

Function
REQ-013 SHALL evaluate conditions 0..15 as: EQ Z; NE !Z; CS C; CC !C; HI L; LS !L; GT N; LE !N; FS F; FC !F; LO !Z&!L; HS Z|L; LT !Z&!N; GE Z|N; UC 1; NV 0.
REQ-014 SHALL define taken = id_valid & (id_kind=11 | ((id_kind=01 | id_kind=10) & cond_true)).
REQ-015 SHALL implement states RUN=00, LU_STALL=01, MEM_WAIT=10, FLUSH=11.
REQ-016 SHALL apply priority in RUN: mem_busy, then (id_valid & load_use), then taken, then idle.
- mem_busy: stall=1, next MEM_WAIT.
- load_use: stall=1, next LU_STALL.
- taken: assert exactly one of Br (01), Jmp (10), JAL (11); next FLUSH.
- idle: all controls 0; stay in RUN.
REQ-017 SHALL behave in LU_STALL as RUN with load_use ignored (one bubble resolves the hazard).
REQ-018 SHALL in MEM_WAIT hold stall=1 while mem_busy=1; when mem_busy=0, act exactly as RUN in that same cycle.
REQ-019 SHALL in FLUSH drive flush=1 and Br=Jmp=JAL=stall=0, ignore id_valid, and go to RUN.
- Exception: if mem_busy=1, drive stall=1 with flush=1 and go to MEM_WAIT.
REQ-020 SHALL never assert more than one of stall, Br, Jmp, JAL in any cycle.
REQ-021 SHALL count consecutive busy cycles in MEM_WAIT with a 4-bit counter, cleared on entry and on exit.
REQ-022 SHALL set mem_timeout when the counter equals 15 and mem_busy is still 1; mem_timeout stays set until reset.
REQ-023 SHALL treat NV Bcond/Jcond as not taken, with no flush.

Reset
REQ-024 SHALL, while reset=0, force state=RUN, watchdog=0, mem_timeout=0 and counters=0, with stall=Br=Jmp=JAL=flush=0, independent of clk.
REQ-025 SHALL, when reset asserts mid-MEM_WAIT or mid-FLUSH, abandon the operation; the first post-reset cycle is RUN with no flush.

Configuration
REQ-026 SHALL gate performance counters with macro PC_CTRL_PERF_EN.
- Defined: redirect_cnt increments on each cycle with Br|Jmp|JAL; stall_cnt increments on each cycle with stall; both saturate at 16'hFFFF.
- Undefined: both ports remain present, are tied to 0, and no counter flops exist.

Verification
REQ-027 SHALL cover: RUN, id_valid=1, kind=01, cond=EQ, Z=1 -> Br=1 one cycle; next cycle flush=1; then RUN.
REQ-028 SHALL cover: kind=01, cond=LT, Z=0, N=1 -> Br=0, flush=0; kind=10, cond=UC -> Jmp=1, then flush=1.
REQ-029 SHALL cover: load_use=1 with taken JAL -> stall=1, JAL=0; next cycle (LU_STALL) JAL=1, then flush=1.
REQ-030 SHALL cover: mem_busy high 20 cycles -> stall=1 for 20 cycles; mem_timeout rises on the 16th busy cycle and stays high; reset=0 clears it asynchronously.
REQ-031 SHALL cover: mem_busy=1 during FLUSH -> stall=1 and flush=1 together; state MEM_WAIT; mem_busy drop -> RUN behaviour in the same cycle.
REQ-032 SHALL cover, with PC_CTRL_PERF_EN defined: 3 redirects and 5 stall cycles -> redirect_cnt=3, stall_cnt=5; without the macro both read 0.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: PC-register control for a pipelined core.
// Decides each cycle whether the fetch stage stalls or redirects (branch,
// conditional jump, JAL), squashes the wrong-path decode slot after a
// redirect, and watches for a data memory that stays busy too long.
//
// Optional feature: define PC_CTRL_PERF_EN to build the redirect/stall
// performance counters. Without it both counter ports read constant 0 and
// no counter flops are built.
//
// Handshake: no valid/ready pair here. id_valid qualifies id_kind/id_cond
// in the same cycle. mem_busy is a level: while it is high the pipeline
// holds and stall is asserted.
//
// state_o exposes the FSM state (00 RUN, 01 LU_STALL, 10 MEM_WAIT,
// 11 FLUSH) for debug and checker binding.
module pc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  id_kind,
  input  logic [3:0]  id_cond,
  input  logic [4:0]  psr_flags,
  input  logic        load_use,
  input  logic        mem_busy,
  output logic        stall,
  output logic        Br,
  output logic        Jmp,
  output logic        JAL,
  output logic        flush,
  output logic        mem_timeout,
  output logic [15:0] redirect_cnt,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_FLUSH    = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q;
  logic       timeout_hit;
  logic       cond_true;
  logic       taken;
  logic       run_eval;
  logic       lu_honor;
  logic       stall_raw, br_raw, jmp_raw, jal_raw, flush_raw;

  // PSR flag fields.
  logic flag_z, flag_c, flag_f, flag_l, flag_n;
  assign flag_z = psr_flags[4];
  assign flag_c = psr_flags[3];
  assign flag_f = psr_flags[2];
  assign flag_l = psr_flags[1];
  assign flag_n = psr_flags[0];

  // Condition-code evaluation against the PSR flags.
  always_comb begin
    cond_true = 1'b0;
    case (id_cond)
      4'd0:  cond_true = flag_z;
      4'd1:  cond_true = ~flag_z;
      4'd2:  cond_true = flag_c;
      4'd3:  cond_true = ~flag_c;
      4'd4:  cond_true = flag_l;
      4'd5:  cond_true = ~flag_l;
      4'd6:  cond_true = flag_n;
      4'd7:  cond_true = ~flag_n;
      4'd8:  cond_true = flag_f;
      4'd9:  cond_true = ~flag_f;
      4'd10: cond_true = ~flag_z & ~flag_l;
      4'd11: cond_true = flag_z | flag_l;
      4'd12: cond_true = ~flag_z & ~flag_n;
      4'd13: cond_true = flag_z | flag_n;
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // JAL is unconditional; Bcond/Jcond follow the condition (NV never taken).
  assign taken = id_valid &
                 ((id_kind == 2'b11) |
                  (((id_kind == 2'b01) | (id_kind == 2'b10)) & cond_true));

  // Next-state, watchdog and raw control decode.
  always_comb begin
    state_d     = state_q;
    wd_cnt_d    = 4'd0;
    timeout_hit = 1'b0;
    run_eval    = 1'b0;
    lu_honor    = 1'b0;
    stall_raw   = 1'b0;
    br_raw      = 1'b0;
    jmp_raw     = 1'b0;
    jal_raw     = 1'b0;
    flush_raw   = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_eval = 1'b1;
        lu_honor = 1'b1;
      end
      ST_LU_STALL: begin
        // The bubble already inserted resolves the hazard.
        run_eval = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          stall_raw   = 1'b1;
          wd_cnt_d    = (wd_cnt_q == 4'd15) ? 4'd15 : wd_cnt_q + 4'd1;
          timeout_hit = (wd_cnt_d == 4'd15);
        end else begin
          // Memory ready: behave as RUN in this same cycle.
          run_eval = 1'b1;
          lu_honor = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_raw = 1'b1;
        if (mem_busy) begin
          stall_raw = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else begin
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        stall_raw = 1'b1;
        state_d   = ST_MEM_WAIT;
      end else if (id_valid && load_use && lu_honor) begin
        stall_raw = 1'b1;
        state_d   = ST_LU_STALL;
      end else if (taken) begin
        br_raw  = (id_kind == 2'b01);
        jmp_raw = (id_kind == 2'b10);
        jal_raw = (id_kind == 2'b11);
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Controls are forced low while reset is held, regardless of clk.
  assign stall       = reset & stall_raw;
  assign Br          = reset & br_raw;
  assign Jmp         = reset & jmp_raw;
  assign JAL         = reset & jal_raw;
  assign flush       = reset & flush_raw;
  assign mem_timeout = reset & (timeout_q | timeout_hit);
  assign state_o     = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [15:0] redirect_cnt_q, stall_cnt_q;

  // Saturating redirect and stall cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      if ((br_raw | jmp_raw | jal_raw) && (redirect_cnt_q != 16'hFFFF))
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if (stall_raw && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = 16'd0;
  assign stall_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scenarios plus randomized traffic for pc_ctrl,
// checked each cycle against a flag-based behavioural model.
module tb_pc_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_kind;
  logic [3:0]  id_cond;
  logic [4:0]  psr_flags;
  logic        load_use;
  logic        mem_busy;
  logic        stall, Br, Jmp, JAL, flush, mem_timeout;
  logic [15:0] redirect_cnt, stall_cnt;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_kind      (id_kind),
    .id_cond      (id_cond),
    .psr_flags    (psr_flags),
    .load_use     (load_use),
    .mem_busy     (mem_busy),
    .stall        (stall),
    .Br           (Br),
    .Jmp          (Jmp),
    .JAL          (JAL),
    .flush        (flush),
    .mem_timeout  (mem_timeout),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
    .state_o      (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Flags describing what the controller owes the pipeline next cycle.
  bit m_flush_pend;   // a redirect was issued last cycle
  bit m_waiting;      // holding for memory
  bit m_bubble_done;  // a load-use bubble was just inserted
  bit m_timeout;
  int m_busy_run;     // busy cycles seen while already holding for memory
  int m_redir;
  int m_stalls;

  function automatic void model_reset();
    m_flush_pend  = 0;
    m_waiting     = 0;
    m_bubble_done = 0;
    m_timeout     = 0;
    m_busy_run    = 0;
    m_redir       = 0;
    m_stalls      = 0;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    bit z, cy, fl, l, n;
    z = f[4]; cy = f[3]; fl = f[2]; l = f[1]; n = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return l;          5: return !l;
      6: return n;          7: return !n;
      8: return fl;         9: return !fl;
      10: return !z && !l;  11: return z || l;
      12: return !z && !n;  13: return z || n;
      14: return 1;         default: return 0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input bit v, input logic [1:0] k, input logic [3:0] c,
                     input logic [4:0] f, input bit lu, input bit mb, input string tag);
    bit e_stall, e_br, e_jmp, e_jal, e_fl, tk, ignore_lu;
    logic [5:0] got_v, exp_v;
    id_valid = v; id_kind = k; id_cond = c; psr_flags = f;
    load_use = lu; mem_busy = mb;
    @(negedge clk);
    e_stall = 0; e_br = 0; e_jmp = 0; e_jal = 0; e_fl = 0;
    tk = v && (k == 3 || ((k == 1 || k == 2) && cond_ok(c, f)));
`ifdef PC_CTRL_PERF_EN
    check({tag, "/redirect_cnt"}, 32'(redirect_cnt), 32'(m_redir));
    check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
`else
    check({tag, "/redirect_cnt"}, 32'(redirect_cnt), 32'd0);
    check({tag, "/stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    if (m_flush_pend) begin
      e_fl = 1;
      e_stall = mb;
      m_flush_pend = 0;
      m_waiting = mb;
      m_busy_run = 0;
      m_bubble_done = 0;
    end else if (m_waiting && mb) begin
      e_stall = 1;
      if (m_busy_run < 15) m_busy_run++;
      if (m_busy_run == 15) m_timeout = 1;
    end else begin
      ignore_lu = m_bubble_done;
      m_waiting = 0;
      m_busy_run = 0;
      m_bubble_done = 0;
      if (mb) begin
        e_stall = 1;
        m_waiting = 1;
      end else if (v && lu && !ignore_lu) begin
        e_stall = 1;
        m_bubble_done = 1;
      end else if (tk) begin
        e_br  = (k == 1);
        e_jmp = (k == 2);
        e_jal = (k == 3);
        m_flush_pend = 1;
      end
    end
    exp_v = {e_stall, e_br, e_jmp, e_jal, e_fl, m_timeout};
    got_v = {stall, Br, Jmp, JAL, flush, mem_timeout};
    exp_q.push_back(32'(exp_v));
    check({tag, "/ctl{stall,Br,Jmp,JAL,flush,to}"}, 32'(got_v), exp_q.pop_front());
    if ((e_br || e_jmp || e_jal) && m_redir < 65535) m_redir++;
    if (e_stall && m_stalls < 65535) m_stalls++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    cyc(0, 2'b00, 4'd0, 5'd0, 0, 0, tag);
  endtask

  // Assert reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #2;
    check({tag, "/ctl_in_reset"}, 32'({stall, Br, Jmp, JAL, flush, mem_timeout}), 32'd0);
    check({tag, "/cnt_in_reset"}, 32'({redirect_cnt, stall_cnt}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset = 1'b0;
    id_valid = 0; id_kind = 0; id_cond = 0; psr_flags = 0;
    load_use = 0; mem_busy = 1;
    #3;
    check("reset/ctl", 32'({stall, Br, Jmp, JAL, flush, mem_timeout}), 32'd0);
    check("reset/state", 32'(state_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Bcond EQ taken, then flush, then back to run.
    cyc(1, 2'b01, 4'd0, 5'b10000, 0, 0, "beq_taken");
    idle("beq_flush");
    idle("beq_run");
    // Bcond LT not taken; Jcond UC taken.
    cyc(1, 2'b01, 4'd12, 5'b00001, 0, 0, "blt_not");
    cyc(1, 2'b10, 4'd14, 5'b00000, 0, 0, "juc_taken");
    cyc(1, 2'b01, 4'd0, 5'b10000, 0, 0, "juc_flush_ignores_valid");
    idle("juc_run");
    // NV never redirects.
    cyc(1, 2'b01, 4'd15, 5'b11111, 0, 0, "bnv");
    cyc(1, 2'b10, 4'd15, 5'b11111, 0, 0, "jnv");
    // Load-use with JAL: one bubble, then JAL, then flush.
    cyc(1, 2'b11, 4'd0, 5'd0, 1, 0, "lu_jal_stall");
    cyc(1, 2'b11, 4'd0, 5'd0, 1, 0, "lu_jal_go");
    idle("lu_jal_flush");
    // Memory busy during flush, then released with a taken branch.
    cyc(1, 2'b11, 4'd0, 5'd0, 0, 0, "fl_busy_jal");
    cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, "fl_busy_flush_stall");
    cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, "fl_busy_wait");
    cyc(1, 2'b01, 4'd0, 5'b10000, 0, 0, "fl_busy_release_br");
    idle("fl_busy_flush2");
    // Long busy: timeout visible from the 16th busy cycle and sticky.
    for (int i = 1; i <= 20; i++) cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, $sformatf("busy%0d", i));
    idle("busy_done");
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    // Reset in the middle of a memory wait.
    cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, "mw_enter");
    cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, "mw_hold");
    do_reset("rst_mid_wait");
    idle("after_rst_wait");
    // Reset in the middle of a flush.
    cyc(1, 2'b11, 4'd0, 5'd0, 0, 0, "pre_fl_jal");
    do_reset("rst_mid_flush");
    idle("after_rst_flush");
    // Three redirects and five stall cycles from a clean start.
    do_reset("rst_perf");
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b01, 4'd14, 5'd0, 0, 0, "perf_br");
      idle("perf_fl");
    end
    for (int i = 0; i < 5; i++) cyc(0, 2'b00, 4'd0, 5'd0, 0, 1, "perf_busy");
    idle("perf_end");
`ifdef PC_CTRL_PERF_EN
    check("perf_redirect_total", 32'(redirect_cnt), 32'd3);
    check("perf_stall_total", 32'(stall_cnt), 32'd5);
`else
    check("perf_redirect_total", 32'(redirect_cnt), 32'd0);
    check("perf_stall_total", 32'(stall_cnt), 32'd0);
`endif

    // Randomized traffic with occasional long busy bursts and resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset("rnd_rst");
      if ($urandom_range(0, 149) == 0) begin
        int len;
        len = $urandom_range(10, 22);
        for (int b = 0; b < len; b++)
          cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, 1, "rnd_burst");
      end else begin
        cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
